// File: rtl/demux_pkg.sv
// Shared constants and mode encoding for the 1-to-16 receive demultiplexer.
package demux_pkg;
  localparam int CH = 16;
  localparam int SW = $clog2(CH);

  typedef enum logic {
    MODE_TDM  = 1'b0,
    MODE_ADDR = 1'b1
  } mode_e;
endpackage

// File: rtl/decoder_4x16.sv
// Combinational one-hot write-enable decoder; all-zero when disabled.
module decoder_4x16
  import demux_pkg::*;
(
  input  logic [SW-1:0] i_idx,
  input  logic          i_en,
  output logic [CH-1:0] o_we
);
  always_comb begin
    o_we = '0;
    if (i_en) o_we[i_idx] = 1'b1;
  end
endmodule

// File: rtl/demux_1x16_tdm.sv
// Registered 1-to-16 demux: addressed bit writes or LSB-first TDM frame assembly.
// All outputs registered, 1-cycle latency; no backpressure, din_valid gates every update.
module demux_1x16_tdm
  import demux_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din,
  input  logic          din_valid,
  input  logic          sof,
  input  logic          mode,
  input  logic [SW-1:0] sel,
  output logic [CH-1:0] y,
  output logic [SW-1:0] slot,
  output logic          frame_valid,
  output logic          err_short
);
  logic [CH-1:0] r_shadow;
  logic [CH-1:0] r_y;
  logic [SW-1:0] r_slot;
  logic          r_frame_valid;
  logic          r_err_short;

  logic          w_tdm;
  logic          w_last;
  logic [SW-1:0] w_idx;
  logic [CH-1:0] w_we;
  logic [CH-1:0] w_din_word;
  logic [CH-1:0] w_shadow_nxt;
  logic [CH-1:0] w_y_addr_nxt;

  assign w_tdm  = (mode_e'(mode) == MODE_TDM);
  assign w_last = (r_slot == SW'(CH - 1));
  // sof always lands in slot 0, whatever the counter currently says
  assign w_idx  = w_tdm ? (sof ? '0 : r_slot) : sel;

  decoder_4x16 u_dec (
    .i_idx (w_idx),
    .i_en  (din_valid),
    .o_we  (w_we)
  );

  assign w_din_word   = din ? w_we : '0;
  assign w_shadow_nxt = (r_shadow & ~w_we) | w_din_word;
  assign w_y_addr_nxt = (r_y & ~w_we) | w_din_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow      <= '0;
      r_y           <= '0;
      r_slot        <= '0;
      r_frame_valid <= 1'b0;
      r_err_short   <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_err_short   <= 1'b0;
      if (!w_tdm) begin
        r_slot <= '0;
        if (din_valid) r_y <= w_y_addr_nxt;
      end else if (din_valid) begin
        r_shadow <= w_shadow_nxt;
        if (sof) begin
          r_slot      <= SW'(1);
          r_err_short <= (r_slot != '0);
        end else if (w_last) begin
          // publish the whole word at once, including this cycle's bit 15
          r_y           <= w_shadow_nxt;
          r_frame_valid <= 1'b1;
          r_slot        <= '0;
        end else begin
          r_slot <= r_slot + SW'(1);
        end
      end
    end
  end

  assign y           = r_y;
  assign slot        = r_slot;
  assign frame_valid = r_frame_valid;
  assign err_short   = r_err_short;
endmodule

// File: tb/tb_demux_1x16_tdm.sv
// Directed bench for demux_1x16_tdm with a bit-list reference model and per-cycle compare.
module tb_demux_1x16_tdm;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        sof = 1'b0;
  logic        mode = 1'b0;
  logic [3:0]  sel = 4'd0;
  logic [15:0] y;
  logic [3:0]  slot;
  logic        frame_valid;
  logic        err_short;

  int n_cmp = 0;
  int n_bad = 0;
  int fv_cnt = 0;
  int err_cnt = 0;

  // reference model: collected bits of the frame in progress plus the published word
  bit          m_bits [16];
  int          m_cnt = 0;
  logic [15:0] m_y = 16'h0;
  logic        m_fv = 1'b0;
  logic        m_err = 1'b0;

  demux_1x16_tdm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .sof         (sof),
    .mode        (mode),
    .sel         (sel),
    .y           (y),
    .slot        (slot),
    .frame_valid (frame_valid),
    .err_short   (err_short)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_y = 16'h0; m_cnt = 0; m_fv = 1'b0; m_err = 1'b0;
      for (int k = 0; k < 16; k++) m_bits[k] = 1'b0;
    end else begin
      m_fv = 1'b0;
      m_err = 1'b0;
      if (mode) begin
        m_cnt = 0;
        if (din_valid) m_y[sel] = din;
      end else if (din_valid) begin
        if (sof) begin
          m_err = (m_cnt != 0);
          m_bits[0] = din;
          m_cnt = 1;
        end else begin
          m_bits[m_cnt] = din;
          m_cnt = m_cnt + 1;
          if (m_cnt == 16) begin
            for (int k = 0; k < 16; k++) m_y[k] = m_bits[k];
            m_fv = 1'b1;
            m_cnt = 0;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_all();
    check("model_y", y, m_y);
    check("model_slot", {12'h0, slot}, 16'(m_cnt));
    check("model_frame_valid", {15'h0, frame_valid}, {15'h0, m_fv});
    check("model_err_short", {15'h0, err_short}, {15'h0, m_err});
    if (frame_valid) fv_cnt++;
    if (err_short) err_cnt++;
  endtask

  task automatic cyc(input logic v, input logic d, input logic s, input logic m, input logic [3:0] se);
    @(negedge clk);
    cmp_all();
    din_valid = v; din = d; sof = s; mode = m; sel = se;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n, input bit use_sof, input int gap);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, w[i], use_sof && (i == 0), 1'b0, 4'd0);
      if (i == 7) repeat (gap) cyc(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    end
  endtask

  task automatic idle(input int n, input logic m);
    repeat (n) cyc(1'b0, 1'b0, 1'b0, m, 4'd0);
  endtask

  initial begin
    idle(3, 1'b0);
    check("rst_y", y, 16'h0000);
    check("rst_slot", {12'h0, slot}, 16'h0);
    check("rst_fv", {15'h0, frame_valid}, 16'h0);
    check("rst_err", {15'h0, err_short}, 16'h0);
    rst_n = 1'b1;
    idle(6, 1'b0);
    check("idle_y", y, 16'h0000);
    check("idle_slot", {12'h0, slot}, 16'h0);
    check("idle_pulses", 16'(fv_cnt + err_cnt), 16'h0);

    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
    idle(1, 1'b1);
    check("addr_sel5", y, 16'h0020);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd15);
    idle(1, 1'b1);
    check("addr_sel15", y, 16'h8020);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 4'd5);
    idle(1, 1'b1);
    check("addr_clr5", y, 16'h8000);
    check("addr_slot", {12'h0, slot}, 16'h0);

    fv_cnt = 0; err_cnt = 0;
    send_bits(16'hA5C3, 16, 1'b1, 0);
    idle(2, 1'b0);
    check("tdm_y", y, 16'hA5C3);
    check("tdm_fv_count", 16'(fv_cnt), 16'd1);

    fv_cnt = 0;
    send_bits(16'hA5C3, 16, 1'b1, 3);
    idle(2, 1'b0);
    check("gap_y", y, 16'hA5C3);
    check("gap_fv_count", 16'(fv_cnt), 16'd1);

    fv_cnt = 0;
    send_bits(16'hBEEF, 16, 1'b1, 0);
    send_bits(16'h0F0F, 16, 1'b0, 0);
    idle(1, 1'b0);
    check("b2b_y", y, 16'h0F0F);
    check("b2b_fv_count", 16'(fv_cnt), 16'd2);
    check("b2b_err_count", 16'(err_cnt), 16'd0);

    fv_cnt = 0; err_cnt = 0;
    send_bits(16'h5A5A, 7, 1'b1, 0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    idle(1, 1'b0);
    check("short_err_count", 16'(err_cnt), 16'd1);
    check("short_slot", {12'h0, slot}, 16'd1);
    check("short_y_held", y, 16'h0F0F);
    check("short_fv_count", 16'(fv_cnt), 16'd0);

    send_bits(16'hFFFF, 14, 1'b0, 0);
    idle(1, 1'b0);
    check("pre15_slot", {12'h0, slot}, 16'd15);
    fv_cnt = 0; err_cnt = 0;
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 4'd0);
    idle(1, 1'b0);
    check("sof15_err_count", 16'(err_cnt), 16'd1);
    check("sof15_fv_count", 16'(fv_cnt), 16'd0);
    check("sof15_slot", {12'h0, slot}, 16'd1);
    check("sof15_y_held", y, 16'h0F0F);

    send_bits(16'h01FF, 8, 1'b0, 0);
    idle(1, 1'b0);
    check("pre_rst_slot", {12'h0, slot}, 16'd9);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_slot", {12'h0, slot}, 16'd0);
    check("midrst_y", y, 16'h0000);
    fv_cnt = 0; err_cnt = 0;
    idle(2, 1'b0);
    rst_n = 1'b1;
    idle(1, 1'b0);
    send_bits(16'h00FF, 16, 1'b1, 0);
    idle(1, 1'b0);
    check("post_rst_y", y, 16'h00FF);
    check("post_rst_fv_count", 16'(fv_cnt), 16'd1);
    check("post_rst_err_count", 16'(err_cnt), 16'd0);

    fv_cnt = 0; err_cnt = 0;
    send_bits(16'h000F, 4, 1'b1, 0);
    idle(1, 1'b0);
    check("pre_switch_slot", {12'h0, slot}, 16'd4);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 4'd12);
    idle(1, 1'b0);
    check("switch_slot", {12'h0, slot}, 16'd0);
    check("switch_y", y, 16'h10FF);
    send_bits(16'h1234, 16, 1'b0, 0);
    idle(2, 1'b0);
    check("resume_y", y, 16'h1234);
    check("resume_fv_count", 16'(fv_cnt), 16'd1);
    check("resume_err_count", 16'(err_cnt), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/demux_1x16_tdm.md
# demux_1x16_tdm

Registered 1-to-16 demultiplexer, the receive-side counterpart of the 16x1 select mux. It routes a single-bit input onto a 16-bit held output bus in one of two modes. In addressed mode, an explicit 4-bit select picks the output bit to update. In TDM mode, an internal slot counter fills a 16-bit frame and publishes it atomically. The block sits after a serialised mux path and rebuilds the parallel word.

## Interface
- `CH`, 16, number of output channels; fixed at 16 for this block.
- `SW`, 4, select/slot width; equals clog2(`CH`).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `din`  in  1  data bit to route.
- `din_valid`  in  1  qualifies `din`; nothing advances or writes when low.
- `sof`  in  1  start of frame; TDM mode only; qualified by `din_valid`.
- `mode`  in  1  0 = TDM auto-slot, 1 = addressed.
- `sel`  in  `SW`  target channel in addressed mode; ignored in TDM mode.
- `y`  out  `CH`  held output word; bit k = channel k.
- `slot`  out  `SW`  next TDM slot to be written.
- `frame_valid`  out  1  one-cycle pulse: `y` holds a freshly completed TDM frame.
- `err_short`  out  1  one-cycle pulse: frame restarted by `sof` before 16 bits arrived.

## Operation
- Reset (async assert, sync to `clk` on release) clears `y` to 16'h0000, the internal shadow register to 0, and `slot` to 0. It also drives `frame_valid` = 0 and `err_short` = 0.
- **Addressed mode** (`mode`=1):
  - Each cycle with `din_valid`=1 writes `y[sel] <= din`; the other 15 bits hold.
  - `slot` is forced to 0 and the shadow register is untouched.
  - `frame_valid` and `err_short` stay 0.
- **TDM mode** (`mode`=0): each valid cycle writes `shadow[slot] <= din`, then `slot <= slot+1`. Slot 0 is the first bit of a frame, so the word is assembled LSB-first.
- **Frame completion:** a valid write at `slot`=15 does the following on the same edge:
  - `y` takes the completed word, with the incoming `din` in bit 15.
  - `frame_valid` pulses.
  - `slot` wraps to 0.
- `y` never shows a partially assembled TDM frame.
- **`sof` with `din_valid`:** `din` is written as slot 0 and `slot` becomes 1.
  - If `slot` was nonzero, the partial frame is abandoned, `err_short` pulses, and `y` is unchanged.
  - If `slot` was 0, there is no error.
- `sof` without `din_valid` is ignored.
- `din_valid`=0 means no write, no slot advance, and both pulses low. Gaps inside a frame are legal.
- **Mode switch:**
  - Sampling `mode`=1 mid-frame discards the partial frame by forcing `slot` to 0. There is no `err_short`.
  - Returning to `mode`=0 starts a new frame at slot 0.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Addressed write latency is 1 cycle: `din`/`sel` sampled at edge N appear on `y` after edge N.
- TDM frame latency is 1 cycle after the 16th valid bit's edge. `frame_valid` is high in exactly the cycle in which `y` first shows the new frame.
- Back-to-back frames run at full rate with no dead cycle: 16 consecutive valid cycles yield one `frame_valid` every 16 cycles.
- When `sof` coincides with `slot`=15, `sof` takes priority: there is no `frame_valid`, `err_short` pulses, and `slot` becomes 1.
- Asserting reset mid-frame clears everything immediately (asynchronously). No pulse is emitted at reset or on release.

## Structure
- Shared package `demux_pkg`:
  - `CH`/`SW` constants.
  - `mode_e` enum (`MODE_TDM`=0, `MODE_ADDR`=1).
- Sub-module `decoder_4x16`: combinational one-hot write-enable from `sel`/`slot` plus enable. Instantiate it once, fed by a mode-selected index.
- Top level holds the shadow register, the output register, the slot counter and the pulse flops. There is no explicit FSM beyond the slot counter.

## Test plan
- Reset → `y`=16'h0000, `slot`=0, both pulses 0. Release, then idle 5 cycles with `din_valid`=0 → all outputs unchanged.
- Addressed mode: `sel`=5, `din`=1, valid → `y`=16'h0020 next cycle. Then `sel`=15, `din`=1 → `y`=16'h8020. Then `sel`=5, `din`=0 → `y`=16'h8000.
- TDM mode: send 16'hA5C3 LSB-first, `sof` on bit 0 → `y`=16'hA5C3 with `frame_valid` high for exactly one cycle.
  - Repeat with 3 idle cycles inserted after bit 7 → same result.
  - `y` is stable until frame end.
- Short frame: `sof` plus 6 further bits, then `sof` again → `err_short` pulses once, `slot`=1, `y` keeps its previous frame, and no `frame_valid`.
- Reset mid-frame after 9 bits → `slot`=0, `y`=0. A following full frame of 16'h00FF yields `y`=16'h00FF with a single `frame_valid`.
- Mode switch at `slot`=4 to addressed mode, then back to TDM → `slot`=0, no `err_short`, and the next 16 bits form a complete frame.
